// File: rtl/uart_mon_pkg.sv
// uart_mon_pkg: shared FSM encoding, ASCII constants and record lengths for the hex sender.
package uart_mon_pkg;
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    // Characters preceding the terminator: "XXXXXXXX XXXXXXXX" or "XXXXXXXX"
    localparam logic [4:0] DUMP_BODY_LEN = 5'd17;
    localparam logic [4:0] PC_BODY_LEN = 5'd8;
    function automatic logic [4:0] rec_len(input logic pc, input logic crlf);
        return (pc ? PC_BODY_LEN : DUMP_BODY_LEN) + (crlf ? 5'd2 : 5'd1);
    endfunction
endpackage

// File: rtl/hex_to_ascii.sv
// hex_to_ascii: one nibble to its uppercase ASCII hex digit.
module hex_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    assign ascii = (nibble < 4'd10) ? 8'h30 + {4'h0, nibble} : 8'h37 + {4'h0, nibble};
endmodule

// File: rtl/rdata_hex_sender.sv
// rdata_hex_sender: formats a captured 64-bit record as ASCII hex and streams it
// byte by byte over a valid/ready UART transmit interface.
module rdata_hex_sender
    import uart_mon_pkg::*;
#(
    parameter bit CRLF = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdata_snd_start,
    input  logic [63:0] rdata_snd,
    input  logic        pc_print_sel,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        flushing_wq,
    output logic        sender_busy
);
    state_t      state, state_nxt;
    logic [4:0]  idx, body_len, last_idx, off;
    logic [63:0] data;
    logic        pc, accept;
    logic [31:0] word;
    logic [2:0]  pos;
    logic [3:0]  nib;
    logic [7:0]  hex, chr;

    hex_to_ascii u_hex (.nibble(nib), .ascii(hex));

    // Current character is decoded purely from the byte index and captured record
    always_comb begin
        body_len = pc ? PC_BODY_LEN : DUMP_BODY_LEN;
        last_idx = rec_len(pc, CRLF) - 5'd1;
        off = idx - body_len;
        word = (idx < 5'd8) ? data[31:0] : data[63:32];
        pos = (idx < 5'd8) ? 3'(5'd7 - idx) : 3'(5'd16 - idx);
        nib = 4'(word >> {pos, 2'b00});
        chr = (idx >= body_len) ? ((CRLF && off == 5'd0) ? ASCII_CR : ASCII_LF)
            : (!pc && idx == 5'd8) ? ASCII_SP : hex;
    end

    always_comb begin
        tx_valid = state == SEND;
        sender_busy = state != IDLE;
        flushing_wq = state == DONE;
        tx_data = tx_valid ? chr : 8'h00;
        accept = tx_valid && tx_ready;
        state_nxt = state;
        if (state == IDLE && rdata_snd_start) state_nxt = SEND;
        if (accept && idx == last_idx) state_nxt = DONE;
        if (state == DONE) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            data <= '0;
            pc <= 1'b0;
        end else if (state == IDLE && rdata_snd_start) begin
            idx <= '0;
            data <= rdata_snd;
            pc <= pc_print_sel;
        end else if (accept) begin
            idx <= (idx == last_idx) ? 5'd0 : idx + 5'd1;
        end
    end
endmodule
